// File: rtl/cpu_types_pkg.sv
// Shared CPU types: vector-mask op codes and default divergence stack depth.
// Consumed by vmask_stack_unit and vmask_lifo.
package cpu_types_pkg;

  localparam int VMASK_DEPTH_DEF = 8;

  typedef enum logic [2:0] {
    MSET,
    MINV,
    MPUSH,
    MPOP,
    MALL
  } vmask_op_t;

endpackage

// File: rtl/vmask_lifo.sv
// Divergence-mask LIFO: sync write, registered read, and a live top-of-stack
// register so the else-path parent is available without read latency.
module vmask_lifo
  import cpu_types_pkg::*;
#(
  parameter int THREADS = 4,
  parameter int DEPTH   = VMASK_DEPTH_DEF,
  localparam int SW     = $clog2(DEPTH) + 1
) (
  input  logic               CLK,
  input  logic               nRST,
  input  logic               push,
  input  logic               pop,
  input  logic               pop_done,
  input  logic [SW-1:0]      sp,
  input  logic [THREADS-1:0] wdata,
  output logic [THREADS-1:0] rdata,
  output logic [THREADS-1:0] top
);

  localparam int AW = $clog2(DEPTH);

  logic [THREADS-1:0] mem [DEPTH];
  logic [SW-1:0]      sp_m1;
  logic [SW-1:0]      sp_m2;

  assign sp_m1 = sp - SW'(1);
  assign sp_m2 = sp - SW'(2);

  always_ff @(posedge CLK) begin
    if (push)
      mem[sp[AW-1:0]] <= wdata;
  end

  // top follows stack[sp-1]; on pop completion it drops to the entry below
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      rdata <= '1;
      top   <= '1;
    end else begin
      if (push)
        top <= wdata;
      if (pop)
        rdata <= mem[sp_m1[AW-1:0]];
      if (pop_done)
        top <= (sp >= SW'(2)) ? mem[sp_m2[AW-1:0]] : '1;
    end
  end

endmodule

// File: rtl/vmask_stack_unit.sv
// Per-thread SIMT execution-mask manager with nested-divergence LIFO.
// Optional VMASK_PERF_EN adds a saturating divergent-cycle counter.
module vmask_stack_unit
  import cpu_types_pkg::*;
#(
  parameter int THREADS = 4,
  parameter int DEPTH   = VMASK_DEPTH_DEF,
  localparam int SW     = $clog2(DEPTH) + 1
) (
  input  logic               CLK,
  input  logic               nRST,
  input  logic               op_valid,
  output logic               op_ready,
  input  vmask_op_t          op,
  input  logic [THREADS-1:0] cond,
  output logic [THREADS-1:0] mask,
  output logic               any_active,
  output logic               all_active,
  output logic [SW-1:0]      sp,
  output logic               ovf,
  output logic               unf,
`ifdef VMASK_PERF_EN
  output logic [31:0]        div_cycles,
`endif
  input  logic               err_clr
);

  localparam logic [0:0] IDLE     = 1'b0;
  localparam logic [0:0] POP_WAIT = 1'b1;

  logic [0:0]         state;
  logic               accept;
  logic               full;
  logic               empty;
  logic               is_set;
  logic               is_inv;
  logic               is_push;
  logic               is_pop;
  logic               is_all;
  logic               pop_done;
  logic               lifo_push;
  logic               lifo_pop;
  logic [THREADS-1:0] rdata;
  logic [THREADS-1:0] top;
  logic [THREADS-1:0] parent;

  assign op_ready   = (state == IDLE);
  assign accept     = op_valid & op_ready;
  assign full       = (sp == SW'(DEPTH));
  assign empty      = (sp == '0);
  assign is_set     = accept & (op == MSET);
  assign is_inv     = accept & (op == MINV);
  assign is_push    = accept & (op == MPUSH);
  assign is_pop     = accept & (op == MPOP);
  assign is_all     = accept & (op == MALL);
  assign pop_done   = (state == POP_WAIT);
  assign lifo_push  = is_push & ~full;
  assign lifo_pop   = is_pop & ~empty;
  assign parent     = empty ? '1 : top;
  assign any_active = |mask;
  assign all_active = &mask;

  vmask_lifo #(
    .THREADS (THREADS),
    .DEPTH   (DEPTH)
  ) u_lifo (
    .CLK      (CLK),
    .nRST     (nRST),
    .push     (lifo_push),
    .pop      (lifo_pop),
    .pop_done (pop_done),
    .sp       (sp),
    .wdata    (mask),
    .rdata    (rdata),
    .top      (top)
  );

  // a new error in the same cycle as err_clr keeps the flag set
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state <= IDLE;
      mask  <= '1;
      sp    <= '0;
      ovf   <= 1'b0;
      unf   <= 1'b0;
    end else begin
      ovf <= (is_push & full) | (ovf & ~err_clr);
      unf <= (is_pop & empty) | (unf & ~err_clr);
      if (pop_done) begin
        mask  <= rdata;
        sp    <= sp - SW'(1);
        state <= IDLE;
      end else begin
        unique case (1'b1)
          is_set: mask <= mask & cond;
          is_inv: mask <= parent & ~mask;
          is_all: mask <= '1;
          is_push: begin
            if (!full)
              sp <= sp + SW'(1);
          end
          is_pop: begin
            if (empty)
              mask <= '1;
            else
              state <= POP_WAIT;
          end
          default: ;
        endcase
      end
    end
  end

`ifdef VMASK_PERF_EN
  always_ff @(posedge CLK) begin
    if (!nRST)
      div_cycles <= '0;
    else if (any_active & ~all_active & ~&div_cycles)
      div_cycles <= div_cycles + 32'd1;
  end
`endif

endmodule

// File: tb/tb_vmask_stack_unit.sv
// Bench for vmask_stack_unit: directed literal checks plus random ops
// compared every cycle against a queue-based op-level model.
module tb_vmask_stack_unit;
  import cpu_types_pkg::*;

  localparam int T  = 4;
  localparam int D  = 8;
  localparam int SW = $clog2(D) + 1;

  logic          CLK = 1'b0;
  logic          nRST = 1'b0;
  logic          op_valid = 1'b0;
  logic          err_clr = 1'b0;
  vmask_op_t     op = MSET;
  logic [T-1:0]  cond = '0;
  logic          op_ready;
  logic [T-1:0]  mask;
  logic          any_active;
  logic          all_active;
  logic [SW-1:0] sp;
  logic          ovf;
  logic          unf;
  logic [31:0]   div_cycles;

  vmask_stack_unit #(.THREADS(T), .DEPTH(D)) dut (
    .CLK        (CLK),
    .nRST       (nRST),
    .op_valid   (op_valid),
    .op_ready   (op_ready),
    .op         (op),
    .cond       (cond),
    .mask       (mask),
    .any_active (any_active),
    .all_active (all_active),
    .sp         (sp),
    .ovf        (ovf),
    .unf        (unf),
`ifdef VMASK_PERF_EN
    .div_cycles (div_cycles),
`endif
    .err_clr    (err_clr)
  );

`ifndef VMASK_PERF_EN
  assign div_cycles = '0;
`endif

  always #5 CLK = ~CLK;

  int total = 0;
  int bad = 0;
  bit chk_on = 1'b0;

  logic [T-1:0] m_mask = '1;
  logic [T-1:0] m_stk[$];
  bit           m_busy = 1'b0;
  bit           m_ovf = 1'b0;
  bit           m_unf = 1'b0;
  longint       m_div = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge CLK) begin : model
    bit so, su;
    logic [T-1:0] par;
    so = 1'b0;
    su = 1'b0;
    if (!nRST) begin
      m_mask = '1;
      m_stk.delete();
      m_busy = 1'b0;
      m_ovf  = 1'b0;
      m_unf  = 1'b0;
      m_div  = 0;
    end else begin
      if (m_mask != '0 && m_mask != '1 && m_div < 64'hFFFF_FFFF)
        m_div++;
      if (m_busy) begin
        m_mask = m_stk.pop_back();
        m_busy = 1'b0;
      end else if (op_valid) begin
        case (op)
          MSET: m_mask = m_mask & cond;
          MINV: begin
            par = (m_stk.size() > 0) ? m_stk[$] : '1;
            m_mask = par & ~m_mask;
          end
          MALL: m_mask = '1;
          MPUSH: begin
            if (m_stk.size() < D) m_stk.push_back(m_mask);
            else so = 1'b1;
          end
          MPOP: begin
            if (m_stk.size() > 0) m_busy = 1'b1;
            else begin
              su = 1'b1;
              m_mask = '1;
            end
          end
          default: ;
        endcase
      end
      m_ovf = so | (m_ovf & !err_clr);
      m_unf = su | (m_unf & !err_clr);
    end
  end

  always @(negedge CLK) begin
    if (chk_on) begin
      chk("mask", 32'(mask), 32'(m_mask));
      chk("any", 32'(any_active), 32'(m_mask != '0));
      chk("all", 32'(all_active), 32'(m_mask == '1));
      chk("sp", 32'(sp), 32'(m_stk.size()));
      chk("ovf", 32'(ovf), 32'(m_ovf));
      chk("unf", 32'(unf), 32'(m_unf));
      chk("ready", 32'(op_ready), 32'(!m_busy));
`ifdef VMASK_PERF_EN
      chk("div", div_cycles, 32'(m_div));
`endif
    end
  end

  task automatic op1(input vmask_op_t o, input logic [T-1:0] c);
    op_valid = 1'b1;
    op = o;
    cond = c;
    @(negedge CLK);
    op_valid = 1'b0;
  endtask

  task automatic rst1();
    nRST = 1'b0;
    @(negedge CLK);
    nRST = 1'b1;
  endtask

  initial begin
    int r;
    repeat (2) @(negedge CLK);
    chk("rst_mask", 32'(mask), 32'hF);
    chk("rst_sp", 32'(sp), 32'h0);
    chk("rst_ovf", 32'(ovf), 32'h0);
    chk("rst_unf", 32'(unf), 32'h0);
    chk("rst_ready", 32'(op_ready), 32'h1);
    chk_on = 1'b1;
    nRST = 1'b1;

    op1(MSET, 4'b0101);
    chk("ie_set1", 32'(mask), 32'h5);
    op1(MPUSH, 4'b0000);
    chk("ie_push", 32'(sp), 32'h1);
    op1(MSET, 4'b0001);
    chk("ie_set2", 32'(mask), 32'h1);
    op1(MINV, 4'b0000);
    chk("ie_inv", 32'(mask), 32'h4);
    op1(MPOP, 4'b0000);
    chk("ie_pop_busy", 32'(op_ready), 32'h0);
    @(negedge CLK);
    chk("ie_pop_mask", 32'(mask), 32'h5);
    chk("ie_pop_sp", 32'(sp), 32'h0);
    chk("ie_pop_ready", 32'(op_ready), 32'h1);

    op_valid = 1'b1;
    op = MPUSH;
    repeat (9) @(negedge CLK);
    op_valid = 1'b0;
    chk("ov_sp", 32'(sp), 32'h8);
    chk("ov_flag", 32'(ovf), 32'h1);
    chk("ov_mask", 32'(mask), 32'h5);
    err_clr = 1'b1;
    @(negedge CLK);
    err_clr = 1'b0;
    chk("ov_clr", 32'(ovf), 32'h0);

    rst1();
    op1(MSET, 4'b0011);
    op1(MPOP, 4'b0000);
    chk("un_mask", 32'(mask), 32'hF);
    chk("un_flag", 32'(unf), 32'h1);
    chk("un_ready", 32'(op_ready), 32'h1);
    chk("un_sp", 32'(sp), 32'h0);

    rst1();
    op1(MSET, 4'b0011);
    op1(MPUSH, 4'b0000);
    op1(MPOP, 4'b0000);
    nRST = 1'b0;
    @(negedge CLK);
    nRST = 1'b1;
    chk("rm_mask", 32'(mask), 32'hF);
    chk("rm_sp", 32'(sp), 32'h0);
    chk("rm_ready", 32'(op_ready), 32'h1);

`ifdef VMASK_PERF_EN
    rst1();
    op1(MSET, 4'b0011);
    chk("pf_zero", div_cycles, 32'd0);
    op_valid = 1'b1;
    repeat (10) @(negedge CLK);
    op_valid = 1'b0;
    chk("pf_ten", div_cycles, 32'd10);
    op1(MALL, 4'b0000);
    repeat (3) @(negedge CLK);
    chk("pf_stop", div_cycles, 32'd11);
`endif

    rst1();
    for (int i = 0; i < 800; i++) begin
      nRST = ($urandom_range(0, 80) != 0);
      op_valid = ($urandom_range(0, 3) != 0);
      r = $urandom_range(0, 9);
      if (i < 400)
        op = (r < 4) ? MPUSH : vmask_op_t'(3'(r % 5));
      else
        op = (r < 4) ? MPOP : vmask_op_t'(3'(r % 5));
      cond = T'($urandom);
      err_clr = ($urandom_range(0, 15) == 0);
      @(negedge CLK);
    end
    nRST = 1'b1;
    op_valid = 1'b0;
    err_clr = 1'b0;
    repeat (2) @(negedge CLK);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
